lcd_write_sequencer: RTL and testbench

- Sequences one 8-bit LCD write over the 4-bit character-LCD bus: upper nibble first, then lower nibble.
- Drives RS and the data nibble, and gates the existing enable-pulse generator by holding it in reset or releasing it.
- Waits for the generator's done pulse after each nibble, then enforces the HD44780 inter-nibble and post-write gaps.
- Sits between the display-content/command FSM (requester) and the enable-pulse generator plus LCD pins.

---
 rtl/lcd_write_sequencer.sv | 101 ++++++++++
 tb/tb_lcd_write_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: sends one byte to a 4-bit HD44780 bus as two nibbles, gating the enable-pulse generator.
// Optional macro LCD_LONG_CMD_DELAY_EN stretches the post-write gap for clear/home commands.
module lcd_write_sequencer #(
  parameter int unsigned SETUP_CYCLES      = 2,
  parameter int unsigned NIBBLE_GAP_CYCLES = 50,
  parameter int unsigned WRITE_GAP_CYCLES  = 2000
`ifdef LCD_LONG_CMD_DELAY_EN
  ,
  parameter int unsigned LONG_GAP_CYCLES   = 82000
`endif
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iEnableDone,
  output logic       oEnableReset,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data,
  output logic       oBusy,
  output logic       oDone
);
  typedef enum logic [2:0] {
    IDLE, SETUP_HI, PULSE_HI, GAP_NIBBLE, SETUP_LO, PULSE_LO, GAP_WRITE, DONE
  } state_t;
  // Zero-length timings collapse to a single cycle.
  localparam logic [31:0] SETUP_LAST = (SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0;
  localparam logic [31:0] NGAP_LAST  = (NIBBLE_GAP_CYCLES > 0) ? NIBBLE_GAP_CYCLES - 1 : 0;
  localparam logic [31:0] WGAP_LAST  = (WRITE_GAP_CYCLES > 0) ? WRITE_GAP_CYCLES - 1 : 0;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, gap_last;
  logic [7:0]  data_q, data_d;
  logic [3:0]  lcd_data_q, lcd_data_d;
  logic        rs_q, rs_d, en_rst_q, en_rst_d, lcd_rs_q, lcd_rs_d;
  logic        busy_q, busy_d, done_q, done_d;
`ifdef LCD_LONG_CMD_DELAY_EN
  localparam logic [31:0] LGAP_LAST = (LONG_GAP_CYCLES > 0) ? LONG_GAP_CYCLES - 1 : 0;
  // Clear is 8'h01, return-home is 8'h02/8'h03, both only as commands.
  assign gap_last = (!rs_q && data_q != 8'h00 && data_q[7:2] == 6'd0) ? LGAP_LAST : WGAP_LAST;
`else
  assign gap_last = WGAP_LAST;
`endif
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rs_d    = rs_q;
    case (state_q)
      IDLE: if (iStart) begin
        state_d = SETUP_HI;
        data_d  = iData;
        rs_d    = iRS;
      end
      SETUP_HI:   if (cnt_q == SETUP_LAST) state_d = PULSE_HI;
      PULSE_HI:   if (iEnableDone) state_d = GAP_NIBBLE;
      GAP_NIBBLE: if (cnt_q == NGAP_LAST) state_d = SETUP_LO;
      SETUP_LO:   if (cnt_q == SETUP_LAST) state_d = PULSE_LO;
      PULSE_LO:   if (iEnableDone) state_d = GAP_WRITE;
      GAP_WRITE:  if (cnt_q == gap_last) state_d = DONE;
      DONE:       state_d = IDLE;
    endcase
    cnt_d      = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
    en_rst_d   = !(state_d == PULSE_HI || state_d == PULSE_LO);
    lcd_rs_d   = (state_d == SETUP_HI || state_d == SETUP_LO) ? rs_d : lcd_rs_q;
    lcd_data_d = (state_d == SETUP_HI) ? data_d[7:4] :
                 (state_d == SETUP_LO) ? data_d[3:0] : lcd_data_q;
    busy_d     = state_d != IDLE;
    done_d     = state_d == DONE;
  end
  // Outputs are registered from next-state values so they line up with the state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      rs_q       <= 1'b0;
      en_rst_q   <= 1'b1;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      en_rst_q   <= en_rst_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_data_q <= lcd_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
  assign oEnableReset = en_rst_q;
  assign oLCD_RS      = lcd_rs_q;
  assign oLCD_RW      = 1'b0;
  assign oLCD_Data    = lcd_data_q;
  assign oBusy        = busy_q;
  assign oDone        = done_q;
endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb_lcd_write_sequencer: random and directed writes checked cycle-by-cycle against an expected output timeline.
module tb_lcd_write_sequencer;
  typedef logic [8:0] vec_t;
  localparam vec_t RESET_VEC = 9'h080;
  logic       Clock = 1'b0, Reset = 1'b1, iStart = 1'b0, iRS = 1'b0, iEnableDone = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       oEnableReset, oLCD_RS, oLCD_RW, oBusy, oDone;
  logic [3:0] oLCD_Data;
  int checks = 0, errors = 0;
  int dly_g = 5, rel = 0, e_rises = 0, done_cnt = 0;
  logic lcd_e = 1'b0, lcd_e_p = 1'b0;
  vec_t q[$];
  lcd_write_sequencer dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iData(iData), .iRS(iRS),
    .iEnableDone(iEnableDone), .oEnableReset(oEnableReset), .oLCD_RS(oLCD_RS),
    .oLCD_RW(oLCD_RW), .oLCD_Data(oLCD_Data), .oBusy(oBusy), .oDone(oDone)
  );
  always #10 Clock = ~Clock;
  // Enable-generator stand-in: E high for dly-1 cycles after release, done on the dly-th; stray done pulses while held.
  always @(negedge Clock) begin
    rel = oEnableReset ? 0 : rel + 1;
    iEnableDone = oEnableReset ? ($urandom_range(0, 7) == 0) : (dly_g != 0 && rel == dly_g);
    lcd_e_p = lcd_e;
    lcd_e = !oEnableReset && rel < dly_g;
    if (lcd_e && !lcd_e_p) e_rises++;
    if (oDone) done_cnt++;
  end
  function automatic vec_t obs();
    return {oLCD_RW, oEnableReset, oLCD_RS, oBusy, oDone, oLCD_Data};
  endfunction
  function automatic void push(int n, logic er, logic rs, logic busy, logic done, logic [3:0] d);
    for (int k = 0; k < n; k++) q.push_back({1'b0, er, rs, busy, done, d});
  endfunction
  function automatic int gap_w(logic [7:0] d, logic r);
`ifdef LCD_LONG_CMD_DELAY_EN
    return (!r && d >= 8'h01 && d <= 8'h03) ? 82000 : 2000;
`else
    return 2000;
`endif
  endfunction
  task automatic check(input string tag, input int idx, input int got, input int exp, output bit ok);
    checks++;
    ok = (got === exp);
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s idx=%0d got=%h exp=%h", tag, idx, got, exp);
    end
  endtask
  task automatic do_write(input logic [7:0] d, input logic r, input int dly, input int inj_busy,
                          input bit inj_done, input int abort_at);
    bit ok;
    q.delete();
    push(2, 1, r, 1, 0, d[7:4]);
    push(dly, 0, r, 1, 0, d[7:4]);
    push(50, 1, r, 1, 0, d[7:4]);
    push(2, 1, r, 1, 0, d[3:0]);
    push(dly, 0, r, 1, 0, d[3:0]);
    push(gap_w(d, r), 1, r, 1, 0, d[3:0]);
    push(1, 1, r, 1, 1, d[3:0]);
    push(3, 1, r, 0, 0, d[3:0]);
    dly_g = dly;
    iData = d;
    iRS = r;
    iStart = 1'b1;
    @(negedge Clock);
    for (int i = 0; i < q.size(); i++) begin
      check($sformatf("write_%h_rs%0d", d, r), i, int'(obs()), int'(q[i]), ok);
      if (!ok || i == abort_at) begin
        Reset = 1'b1;
        #1;
        if (ok) check("async_reset", i, int'(obs()), int'(RESET_VEC), ok);
        @(negedge Clock);
        Reset = 1'b0;
        break;
      end
      iStart = (i == inj_busy) || (inj_done && i == q.size() - 4);
      iData = 8'($urandom);
      iRS = 1'($urandom);
      @(negedge Clock);
    end
    iStart = 1'b0;
  endtask
  initial begin
    bit ok;
    int e0, d0;
    repeat (3) @(negedge Clock);
    check("reset_state", 0, int'(obs()), int'(RESET_VEC), ok);
    Reset = 1'b0;
    @(negedge Clock);
    check("idle_after_reset", 0, int'(obs()), int'(RESET_VEC), ok);
    d0 = done_cnt;
    do_write(8'h41, 1'b1, 5, -1, 1'b0, -1);
    check("one_done_41", 0, done_cnt - d0, 1, ok);
    e0 = e_rises;
    do_write(8'h28, 1'b0, 5, -1, 1'b0, -1);
    check("two_enable_windows", 0, e_rises - e0, 2, ok);
    d0 = done_cnt;
    do_write(8'($urandom_range(4, 255)), 1'($urandom), 3, 60, 1'b1, -1);
    check("start_while_busy_one_done", 0, done_cnt - d0, 1, ok);
    repeat (3) @(negedge Clock);
    check("no_queued_write", 0, int'(oBusy), 0, ok);
    d0 = done_cnt;
    do_write(8'hA6, 1'b0, 4, -1, 1'b0, 2 + 4 + 10);
    check("abort_no_done", 0, done_cnt - d0, 0, ok);
    check("idle_after_abort", 0, int'(obs()), int'(RESET_VEC), ok);
    d0 = done_cnt;
    do_write(8'h55, 1'b1, 5, -1, 1'b0, -1);
    check("done_after_abort", 0, done_cnt - d0, 1, ok);
    do_write(8'h01, 1'b0, 2, -1, 1'b0, -1);
    do_write(8'h01, 1'b1, 2, -1, 1'b0, -1);
`ifndef LCD_LONG_CMD_DELAY_EN
    for (int n = 0; n < 4; n++)
      do_write(8'($urandom_range(4, 255)), 1'($urandom), $urandom_range(1, 8), -1, 1'b0, -1);
`endif
    d0 = done_cnt;
    dly_g = 0;
    iData = 8'h9C;
    iRS = 1'b1;
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
    repeat (2) @(negedge Clock);
    for (int i = 0; i < 500; i++) begin
      check("stuck_pulse_hi", i, int'(obs()), int'(9'h069), ok);
      if (!ok) break;
      @(negedge Clock);
    end
    check("stuck_no_done", 0, done_cnt - d0, 0, ok);
    Reset = 1'b1;
    #1;
    check("stuck_reset", 0, int'(obs()), int'(RESET_VEC), ok);
    @(negedge Clock);
    Reset = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
